// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU sequencer.
package multicycle_ctrl_pkg;

  localparam int W_CPU        = 32;
  localparam int W_MEM_CMD    = 2;
  localparam int W_PC_SRC     = 2;
  localparam int W_CTRL_STATE = 3;

  localparam logic [W_MEM_CMD-1:0] MEM_NOP   = 2'd0;
  localparam logic [W_MEM_CMD-1:0] MEM_READ  = 2'd1;
  localparam logic [W_MEM_CMD-1:0] MEM_WRITE = 2'd2;

  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;

  localparam logic [5:0] OP_ZERO = 6'h00;
  localparam logic [5:0] F_BREAK = 6'h0D;

  typedef enum logic [W_CTRL_STATE-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } ctrl_state_e;

  // BREAK is an R-type (opcode zero) with the BREAK function code.
  function automatic logic is_break(input logic [W_CPU-1:0] inst);
    return (inst[31:26] == OP_ZERO) && (inst[5:0] == F_BREAK);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle of decode inputs, memory handshake and commit controls around the sequencer.
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  logic [W_CPU-1:0]        inst;
  logic                    d_reg_wen;
  logic [W_MEM_CMD-1:0]    d_mem_cmd;
  logic [W_PC_SRC-1:0]     d_pc_src;
  logic                    mem_ack;
  logic                    mem_req;
  logic [W_MEM_CMD-1:0]    mem_cmd;
  logic                    mem_addr_sel;
  logic                    ir_wen;
  logic                    pc_wen;
  logic [W_PC_SRC-1:0]     pc_src;
  logic                    reg_wen;
  logic                    halted;
  logic                    fault;
  logic [W_CTRL_STATE-1:0] state;
  logic [31:0]             retired;

  modport master (
    input  inst, d_reg_wen, d_mem_cmd, d_pc_src, mem_ack,
    output mem_req, mem_cmd, mem_addr_sel, ir_wen, pc_wen, pc_src,
           reg_wen, halted, fault, state, retired
  );

  modport slave (
    output inst, d_reg_wen, d_mem_cmd, d_pc_src, mem_ack,
    input  mem_req, mem_cmd, mem_addr_sel, ir_wen, pc_wen, pc_src,
           reg_wen, halted, fault, state, retired
  );

endinterface

// File: rtl/multicycle_ctrl_mem_wdog.sv
// Memory watchdog: counts consecutive unacknowledged request cycles and flags
// the cycle in which the MEM_TIMEOUT-th such cycle occurs. MEM_TIMEOUT=0 disables it.
module mem_wdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: cleared when no wait is pending, saturates at the last legal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && busy && !clr && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer sharing one memory port between fetch and data access.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  ctrl_state_e state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        mem_req;
  logic        wdog_busy;
  logic        wdog_expired;

  assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wdog_busy = mem_req && !bus.mem_ack;

  mem_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!wdog_busy),
    .busy    (wdog_busy),
    .expired (wdog_expired)
  );

  // Next state, retire count and Moore-decoded outputs (ir_wen also looks at ack)
  always_comb begin
    state_d          = state_q;
    retired_d        = retired_q;
    bus.mem_cmd      = MEM_NOP;
    bus.mem_addr_sel = ADDR_SEL_PC;
    bus.ir_wen       = 1'b0;
    bus.pc_wen       = 1'b0;
    bus.pc_src       = '0;
    bus.reg_wen      = 1'b0;
    bus.halted       = 1'b0;
    bus.fault        = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_cmd      = MEM_READ;
        bus.mem_addr_sel = ADDR_SEL_PC;
        bus.ir_wen       = bus.mem_ack;
        if (bus.mem_ack)       state_d = S_DECODE;
        else if (wdog_expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (is_break(bus.inst)) begin
          state_d   = S_HALT;
          retired_d = retired_q + 32'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = (bus.d_mem_cmd != MEM_NOP) ? S_MEM : S_WB;
      S_MEM: begin
        bus.mem_cmd      = bus.d_mem_cmd;
        bus.mem_addr_sel = ADDR_SEL_ALU;
        if (bus.mem_ack)       state_d = S_WB;
        else if (wdog_expired) state_d = S_FAULT;
      end
      S_WB: begin
        bus.reg_wen = bus.d_reg_wen;
        bus.pc_wen  = 1'b1;
        bus.pc_src  = bus.d_pc_src;
        retired_d   = retired_q + 32'd1;
        state_d     = S_FETCH;
      end
      S_HALT:  bus.halted = 1'b1;
      S_FAULT: bus.fault  = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // State and retired-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign bus.mem_req = mem_req;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule
